// File: rtl/nn_pkg.sv
// Shared types and widths for the neuron-layer multiplier sharing logic.
package nn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START     = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_RETURN    = 2'd3
    } arb_st_e;

    localparam int unsigned ActvWidth     = 32;
    localparam int unsigned TxnCountWidth = 16;

endpackage

// File: rtl/mult_arbiter_rr_pick.sv
// Round-robin picker: first set request at or above ptr, searching upward with wrap.
module rr_pick
    import nn_pkg::*;
#(
    parameter int NumReq   = 4,
    parameter int IdxWidth = $clog2(NumReq)
) (
    input  logic [NumReq-1:0]   req,
    input  logic [IdxWidth-1:0] ptr,
    output logic [NumReq-1:0]   gnt,
    output logic [IdxWidth-1:0] idx
);

    // Rotating search; the first hit blocks every later candidate.
    always_comb begin
        logic found_s;
        logic hit_s;
        int   cand_s;
        gnt     = '0;
        idx     = '0;
        found_s = 1'b0;
        hit_s   = 1'b0;
        cand_s  = 0;
        for (int k = 0; k < NumReq; k++) begin
            cand_s      = (int'(ptr) + k >= NumReq) ? (int'(ptr) + k - NumReq) : (int'(ptr) + k);
            hit_s       = !found_s && req[cand_s];
            gnt[cand_s] = hit_s;
            idx         = hit_s ? IdxWidth'(cand_s) : idx;
            found_s     = found_s | hit_s;
        end
    end

endmodule

// File: rtl/mult_arbiter.sv
// Shares one multiplier datapath among NumReq requesters: round-robin grant,
// operand latching, start/done handshakes and per-requester result return.
module mult_arbiter
    import nn_pkg::*;
#(
    parameter int NumReq       = 4,
    parameter int DataWidth    = 8,
    parameter int WeigthsWidth = DataWidth,
    parameter int Layer        = 0
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic [NumReq-1:0]              req_i,
    input  logic [NumReq*DataWidth-1:0]    actv_i,
    input  logic [NumReq*WeigthsWidth-1:0] weights_i,
    input  logic [NumReq*ActvWidth-1:0]    bias_i,
    output logic [NumReq-1:0]              gnt_o,
    output logic [NumReq-1:0]              req_done_o,
    input  logic [NumReq-1:0]              req_ack_i,
    output logic [ActvWidth-1:0]           result_o,
    output logic                           busy_o,
    output logic [TxnCountWidth-1:0]       txn_count_o,
    output logic                           mult_start_o,
    input  logic                           mult_ack_i,
    output logic [DataWidth-1:0]           mult_actv_o,
    output logic [WeigthsWidth-1:0]        mult_weights_o,
    output logic [ActvWidth-1:0]           mult_bias_o,
    input  logic [ActvWidth-1:0]           mult_actv_i,
    input  logic                           mult_done_i,
    output logic                           mult_ack_o
);

    localparam int IdxWidth = $clog2(NumReq);

    if (Layer < 0) begin : g_layer_range
        $error("mult_arbiter: Layer must be non-negative");
    end

    arb_st_e                    state_q;
    logic [IdxWidth-1:0]        ptr_q, ptr_d;
    logic [IdxWidth-1:0]        gidx_q;
    logic [NumReq-1:0]          gnt_q, done_q;
    logic [ActvWidth-1:0]       result_q;
    logic                       busy_q, start_q, mack_q;
    logic [TxnCountWidth-1:0]   txn_q, txn_d;
    logic [DataWidth-1:0]       actv_q, sel_actv_s;
    logic [WeigthsWidth-1:0]    wt_q, sel_wt_s;
    logic [ActvWidth-1:0]       bias_q, sel_bias_s;
    logic [NumReq-1:0]          pick_gnt_s;
    logic [IdxWidth-1:0]        pick_idx_s;

    rr_pick #(
        .NumReq   (NumReq),
        .IdxWidth (IdxWidth)
    ) u_rr_pick (
        .req (req_i),
        .ptr (ptr_q),
        .gnt (pick_gnt_s),
        .idx (pick_idx_s)
    );

    // Operand mux for the candidate winner, plus pointer/counter successors.
    always_comb begin
        sel_actv_s = '0;
        sel_wt_s   = '0;
        sel_bias_s = '0;
        for (int i = 0; i < NumReq; i++) begin
            sel_actv_s = (pick_idx_s == IdxWidth'(i)) ? actv_i[i*DataWidth +: DataWidth] : sel_actv_s;
            sel_wt_s   = (pick_idx_s == IdxWidth'(i)) ? weights_i[i*WeigthsWidth +: WeigthsWidth] : sel_wt_s;
            sel_bias_s = (pick_idx_s == IdxWidth'(i)) ? bias_i[i*ActvWidth +: ActvWidth] : sel_bias_s;
        end
        ptr_d = (gidx_q == IdxWidth'(NumReq - 1)) ? '0 : gidx_q + IdxWidth'(1);
        txn_d = txn_q + TxnCountWidth'(1);
    end

    // Transaction sequencer with all outputs registered.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            gidx_q   <= '0;
            gnt_q    <= '0;
            done_q   <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            start_q  <= 1'b0;
            mack_q   <= 1'b0;
            txn_q    <= '0;
            actv_q   <= '0;
            wt_q     <= '0;
            bias_q   <= '0;
        end else begin
            mack_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req_i != '0) begin
                        gnt_q   <= pick_gnt_s;
                        gidx_q  <= pick_idx_s;
                        actv_q  <= sel_actv_s;
                        wt_q    <= sel_wt_s;
                        bias_q  <= sel_bias_s;
                        start_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
                    if (mult_ack_i) begin
                        start_q <= 1'b0;
                        state_q <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (mult_done_i) begin
                        result_q <= mult_actv_i;
                        mack_q   <= 1'b1;
                        done_q   <= gnt_q;
                        state_q  <= ST_RETURN;
                    end
                end
                ST_RETURN: begin
                    if (req_ack_i[gidx_q]) begin
                        gnt_q   <= '0;
                        done_q  <= '0;
                        ptr_q   <= ptr_d;
                        txn_q   <= txn_d;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    gnt_q   <= '0;
                    done_q  <= '0;
                    start_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt_o          = gnt_q;
    assign req_done_o     = done_q;
    assign result_o       = result_q;
    assign busy_o         = busy_q;
    assign txn_count_o    = txn_q;
    assign mult_start_o   = start_q;
    assign mult_ack_o     = mack_q;
    assign mult_actv_o    = actv_q;
    assign mult_weights_o = wt_q;
    assign mult_bias_o    = bias_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: transaction-level reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_mult_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;

    logic              clk_i = 1'b0;
    logic              reset_i;
    logic [N-1:0]      req_i;
    logic [N*DW-1:0]   actv_i;
    logic [N*DW-1:0]   weights_i;
    logic [N*32-1:0]   bias_i;
    logic [N-1:0]      gnt_o;
    logic [N-1:0]      req_done_o;
    logic [N-1:0]      req_ack_i;
    logic [31:0]       result_o;
    logic              busy_o;
    logic [15:0]       txn_count_o;
    logic              mult_start_o;
    logic              mult_ack_i;
    logic [DW-1:0]     mult_actv_o;
    logic [DW-1:0]     mult_weights_o;
    logic [31:0]       mult_bias_o;
    logic [31:0]       mult_actv_i;
    logic              mult_done_i;
    logic              mult_ack_o;

    int checks = 0;
    int errors = 0;

    mult_arbiter #(.NumReq(N), .DataWidth(DW), .WeigthsWidth(DW), .Layer(0)) dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .req_i          (req_i),
        .actv_i         (actv_i),
        .weights_i      (weights_i),
        .bias_i         (bias_i),
        .gnt_o          (gnt_o),
        .req_done_o     (req_done_o),
        .req_ack_i      (req_ack_i),
        .result_o       (result_o),
        .busy_o         (busy_o),
        .txn_count_o    (txn_count_o),
        .mult_start_o   (mult_start_o),
        .mult_ack_i     (mult_ack_i),
        .mult_actv_o    (mult_actv_o),
        .mult_weights_o (mult_weights_o),
        .mult_bias_o    (mult_bias_o),
        .mult_actv_i    (mult_actv_i),
        .mult_done_i    (mult_done_i),
        .mult_ack_o     (mult_ack_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: one owner at a time, phases tracked as flags.
    int          m_owner = -1;
    int          m_ptr   = 0;
    int          m_c;
    bit          m_valid = 1'b0;
    logic        m_start = 1'b0, m_done = 1'b0, m_mack = 1'b0;
    logic [31:0] m_result = '0, m_bias = '0;
    logic [15:0] m_txn = '0;
    logic [7:0]  m_actv = '0, m_wt = '0;

    always @(posedge clk_i) begin
        m_mack = 1'b0;
        if (reset_i) begin
            m_valid = 1'b1; m_owner = -1; m_ptr = 0; m_start = 1'b0; m_done = 1'b0;
            m_result = '0; m_txn = '0; m_actv = '0; m_wt = '0; m_bias = '0;
        end else if (m_owner < 0) begin
            if (req_i != '0) begin
                for (int k = 0; k < N; k++) begin
                    m_c = (m_ptr + k) % N;
                    if (m_owner < 0 && req_i[m_c]) m_owner = m_c;
                end
                m_actv  = actv_i[m_owner*DW +: DW];
                m_wt    = weights_i[m_owner*DW +: DW];
                m_bias  = bias_i[m_owner*32 +: 32];
                m_start = 1'b1;
            end
        end else if (m_start) begin
            if (mult_ack_i) m_start = 1'b0;
        end else if (!m_done) begin
            if (mult_done_i) begin
                m_result = mult_actv_i; m_mack = 1'b1; m_done = 1'b1;
            end
        end else if (req_ack_i[m_owner]) begin
            m_ptr = (m_owner + 1) % N; m_txn = m_txn + 16'd1; m_owner = -1; m_done = 1'b0;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk_i) begin
        if (m_valid) begin
            chk("m_gnt",    32'(gnt_o),        (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
            chk("m_done",   32'(req_done_o),   m_done ? (32'd1 << m_owner) : 32'd0);
            chk("m_result", result_o,          m_result);
            chk("m_busy",   32'(busy_o),       32'(m_owner >= 0));
            chk("m_txn",    32'(txn_count_o),  32'(m_txn));
            chk("m_start",  32'(mult_start_o), 32'(m_start));
            chk("m_mack",   32'(mult_ack_o),   32'(m_mack));
            chk("m_actv",   32'(mult_actv_o),  32'(m_actv));
            chk("m_wt",     32'(mult_weights_o), 32'(m_wt));
            chk("m_bias",   mult_bias_o,       m_bias);
        end
    end

    task automatic tick();
        @(negedge clk_i);
    endtask

    task automatic wait_gnt(input int g);
        int n;
        n = 0;
        while (gnt_o == '0 && n < 20) begin
            tick();
            n++;
        end
        chk("grant", 32'(gnt_o), 32'd1 << g);
    endtask

    // Multiplier acks one cycle after it first sees start.
    task automatic start_hs();
        chk("start_high", 32'(mult_start_o), 32'd1);
        tick();
        mult_ack_i = 1'b1;
        tick();
        mult_ack_i = 1'b0;
        chk("start_low", 32'(mult_start_o), 32'd0);
    endtask

    task automatic finish_mult(input int g, input logic [31:0] res);
        repeat (2) tick();
        mult_actv_i = res;
        mult_done_i = 1'b1;
        tick();
        mult_done_i = 1'b0;
        chk("req_done", 32'(req_done_o), 32'd1 << g);
        chk("mack_pulse", 32'(mult_ack_o), 32'd1);
        chk("result", result_o, res);
        tick();
        chk("mack_low", 32'(mult_ack_o), 32'd0);
    endtask

    task automatic give_ack(input int g);
        req_ack_i = N'(1 << g);
        tick();
        req_ack_i = '0;
        chk("gnt_cleared", 32'(gnt_o), 32'd0);
    endtask

    initial begin
        int macks;
        reset_i = 1'b1; req_i = '0; actv_i = '0; weights_i = '0; bias_i = '0;
        req_ack_i = '0; mult_ack_i = 1'b0; mult_actv_i = '0; mult_done_i = 1'b0;
        repeat (2) tick();
        reset_i = 1'b0;
        chk("rst_gnt", 32'(gnt_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_txn", 32'(txn_count_o), 32'd0);

        // Single request
        actv_i[7:0] = 8'h11; weights_i[7:0] = 8'h22; bias_i[31:0] = 32'd5;
        req_i = 4'b0001;
        wait_gnt(0);
        req_i = '0;
        chk("t1_bias", mult_bias_o, 32'd5);
        chk("t1_actv", 32'(mult_actv_o), 32'h11);
        start_hs();
        finish_mult(0, 32'h2A);
        give_ack(0);
        chk("t1_txn", 32'(txn_count_o), 32'd1);

        // Four continuous requesters after a fresh reset
        reset_i = 1'b1; tick(); reset_i = 1'b0;
        req_i = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            wait_gnt(t % N);
            if (t == 4) req_i = '0;
            start_hs();
            finish_mult(t % N, 32'h100 + 32'(t));
            give_ack(t % N);
        end
        chk("t2_txn", 32'(txn_count_o), 32'd5);

        // Operand hold: requester 2 changes its activation after grant
        actv_i[23:16] = 8'h77; bias_i[95:64] = 32'hCAFE;
        req_i = 4'b0100;
        wait_gnt(2);
        req_i = '0;
        actv_i[23:16] = 8'h99;
        start_hs();
        chk("t3_hold", 32'(mult_actv_o), 32'h77);
        finish_mult(2, 32'h3);
        chk("t3_hold2", 32'(mult_actv_o), 32'h77);
        give_ack(2);

        // Late requester ack with a stray second done pulse
        req_i = 4'b1000;
        wait_gnt(3);
        req_i = '0;
        start_hs();
        finish_mult(3, 32'hDEADBEEF);
        macks = 1;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin mult_done_i = 1'b1; mult_actv_i = 32'h1234; end
            if (i == 4) mult_done_i = 1'b0;
            tick();
            if (mult_ack_o) macks++;
            chk("t4_result", result_o, 32'hDEADBEEF);
            chk("t4_done", 32'(req_done_o), 32'b1000);
        end
        chk("t4_mack_once", 32'(macks), 32'd1);
        give_ack(3);
        chk("t4_txn", 32'(txn_count_o), 32'd7);

        // Stray acks in idle and to a non-granted requester
        mult_ack_i = 1'b1; req_ack_i = 4'b1000;
        repeat (2) tick();
        mult_ack_i = 1'b0; req_ack_i = '0;
        chk("t5_busy", 32'(busy_o), 32'd0);
        chk("t5_txn", 32'(txn_count_o), 32'd7);
        req_i = 4'b0010;
        wait_gnt(1);
        req_i = '0;
        start_hs();
        finish_mult(1, 32'h55);
        req_ack_i = 4'b1000;
        repeat (2) tick();
        req_ack_i = '0;
        chk("t5_done_held", 32'(req_done_o), 32'b0010);
        give_ack(1);
        chk("t5_txn2", 32'(txn_count_o), 32'd8);

        // Reset while waiting for the multiplier result
        req_i = 4'b0100;
        wait_gnt(2);
        req_i = '0;
        start_hs();
        tick();
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        chk("t6_gnt", 32'(gnt_o), 32'd0);
        chk("t6_busy", 32'(busy_o), 32'd0);
        chk("t6_txn", 32'(txn_count_o), 32'd0);
        chk("t6_actv", 32'(mult_actv_o), 32'd0);
        chk("t6_bias", mult_bias_o, 32'd0);
        req_i = 4'b0110;
        wait_gnt(1);
        req_i = '0;
        start_hs();
        finish_mult(1, 32'h66);
        give_ack(1);
        chk("t6_txn2", 32'(txn_count_o), 32'd1);

        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_arbiter.md
# mult_arbiter

Round-robin arbiter and sequencer that shares one `multiplier` neuron datapath among `NumReq` requesters, typically the neurons of one layer. It registers the winning requester's activation, weight and bias operands and drives the multiplier's start/ack handshake. It captures the 32-bit activated result and returns it to the owning requester over a per-requester done/ack handshake. Only one transaction is in flight at a time; a grant is never revoked.

## Interface
- `NumReq`, 4, number of requesters (≥2)
- `DataWidth`, 8, activation vector width per requester
- `WeigthsWidth`, `DataWidth`, weight vector width per requester
- `Layer`, 0, forwarded to the multiplier instance context only; no effect on arbitration

Ports:
- `clk_i`  in  1  single clock
- `reset_i`  in  1  reset; synchronous, active-high
- `req_i`  in  NumReq  request per requester
- `actv_i`  in  NumReq×DataWidth  packed activation operands, slot i = requester i
- `weights_i`  in  NumReq×WeigthsWidth  packed weight operands
- `bias_i`  in  NumReq×32  packed bias operands
- `gnt_o`  out  NumReq  one-hot grant, held for the whole transaction
- `req_done_o`  out  NumReq  one-hot result valid
- `req_ack_i`  in  NumReq  result accepted
- `result_o`  out  32  registered result, valid while any `req_done_o` is high
- `busy_o`  out  1  high in any state except ST_IDLE
- `txn_count_o`  out  16  completed transactions, wraps 0xFFFF→0
- `mult_start_o` / `mult_ack_i`  out/in  1  start handshake to the multiplier
- `mult_actv_o`, `mult_weights_o`, `mult_bias_o`  out  DataWidth/WeigthsWidth/32  registered operands
- `mult_actv_i` / `mult_done_i`  in  32/1  multiplier result and done
- `mult_ack_o`  out  1  result acknowledge to the multiplier

## Operation
- States: ST_IDLE, ST_START, ST_WAIT_DONE, ST_RETURN.
- ST_IDLE:
  - If `req_i` is nonzero, pick the winner g = first set bit at or after `prio_ptr`, searching upward with wrap.
  - Latch g's operands into the `mult_*` registers.
  - Set `gnt_o[g]` and `mult_start_o`, then go to ST_START.
- ST_START: hold `mult_start_o` until `mult_ack_i`. In the cycle `mult_ack_i` is sampled high, clear `mult_start_o` and go to ST_WAIT_DONE.
- ST_WAIT_DONE: on `mult_done_i`:
  - Capture `mult_actv_i` into `result_o`.
  - Pulse `mult_ack_o` for exactly one cycle.
  - Set `req_done_o[g]` and go to ST_RETURN.
- ST_RETURN:
  - Hold `req_done_o[g]` and `result_o` until `req_ack_i[g]`.
  - `mult_done_i` is ignored in this state.
  - On `req_ack_i[g]`: clear `gnt_o` and `req_done_o`, set `prio_ptr` to (g+1) mod NumReq, increment `txn_count_o`, and go to ST_IDLE.
- Operands are registered at grant, so requesters may change `actv_i`/`weights_i`/`bias_i` after `gnt_o` rises.
- A requester may drop `req_i` after grant. The transaction still completes and the requester must still ack.
- `req_ack_i` bits for non-granted requesters, and any `req_ack_i` outside ST_RETURN, are ignored.
- `mult_ack_i` outside ST_START and `mult_done_i` outside ST_WAIT_DONE are ignored.
- Reset mid-transaction:
  - Return to ST_IDLE, `prio_ptr`=0, all outputs 0.
  - The multiplier shares `reset_i`, so both sides restart together.

## Timing
- Reset values: `gnt_o`, `req_done_o`, `result_o`, `busy_o`, `txn_count_o`, `mult_start_o`, `mult_ack_o`, and all `mult_*` operand outputs are 0. `prio_ptr`=0.
- All outputs are registered; there are no combinational paths from input to output.
- Request sampled at edge N → `gnt_o` and `mult_start_o` high from N+1.
- With the multiplier answering `mult_ack_i` one cycle after it sees start, `mult_start_o` is high for 2 cycles.
- `mult_done_i` sampled at edge M → `req_done_o` and `mult_ack_o` high from M+1. `mult_ack_o` is low from M+2.
- `req_ack_i` sampled at edge K → `gnt_o` low from K+1 and ST_IDLE from K+1. The next grant is visible at K+2 at the earliest; there is 1 idle cycle between transactions.
- Simultaneous requests: the winner is the lowest index at or above `prio_ptr`, with wrap. A requester that is continuously requesting waits at most NumReq−1 transactions.

## Structure
- `nn_pkg` holds:
  - `arb_st_e` (the 4-state enum, `logic [1:0]`)
  - `ActvWidth`=32 (result/bias width)
  - `TxnCountWidth`=16
- One sub-module, `rr_pick`: purely combinational; inputs `req`, `ptr`; outputs one-hot `gnt` and binary `idx`.
- The operand mux and registers, the FSM and the counter stay in `mult_arbiter`.

## Test plan
- **Single request:** `req_i`=0001, bias 5; model returns `mult_actv_i`=0x2A → `gnt_o`=0001, `result_o`=0x2A, `req_done_o`=0001, `txn_count_o`=1 after ack.
- **All four request simultaneously and continuously:** grant order 0,1,2,3,0; `txn_count_o`=5 after the fifth ack.
- **Operand hold:** requester 2 changes `actv_i` one cycle after grant → `mult_actv_o` keeps the value latched at grant until ST_IDLE.
- **Late requester ack:** requester delays `req_ack_i` by 10 cycles → `req_done_o` and `result_o` stay stable; `mult_ack_o` pulses exactly once; a second `mult_done_i` pulse is ignored.
- **Stray acks:** `req_ack_i` to non-granted index 3 and `mult_ack_i` in ST_IDLE → no state change.
- **Reset in ST_WAIT_DONE:** all outputs 0 next cycle; next request from requester 2 with `req_i`=0110 grants 1 (`prio_ptr` reset to 0).
